// File: rtl/sobel_pkg.sv
// Shared types for the Sobel front end: tracker state, pixel tag layout and
// the helper that derives position flags from a column/row pair.
package sobel_pkg;

  localparam int IMG_W = 640;
  localparam int IMG_H = 480;
  // Tag fields are wide enough for any geometry up to 65536 x 65536.
  localparam int TAG_W = 16;

  typedef enum logic {S_IDLE, S_ACTIVE} rt_state_e;

  typedef struct packed {
    logic [TAG_W-1:0] col;
    logic [TAG_W-1:0] row;
    logic             sof;
    logic             eol;
    logic             eof;
    logic             border;
    logic             win_valid;
  } pixel_tag_t;

  // Position flags for pixel (col,row) of a w x h frame.
  function automatic pixel_tag_t make_tag(input logic [TAG_W-1:0] col,
                                          input logic [TAG_W-1:0] row,
                                          input int w, input int h);
    pixel_tag_t t;
    t.col       = col;
    t.row       = row;
    t.sof       = (col == '0) && (row == '0);
    t.eol       = (col == TAG_W'(w - 1));
    t.eof       = (col == TAG_W'(w - 1)) && (row == TAG_W'(h - 1));
    t.border    = (row == '0) || (row == TAG_W'(h - 1)) ||
                  (col == '0) || (col == TAG_W'(w - 1));
    t.win_valid = (row >= TAG_W'(2)) && (col >= TAG_W'(2));
    return t;
  endfunction

endpackage

// File: rtl/raster_tracker_counter.sv
// Generic up/down counter with synchronous load and rollover at MAX_P.
module raster_tracker_counter #(
  parameter int W_P   = 10,
  parameter int MAX_P = 639
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic           en_i,
  input  logic           up_i,
  input  logic           load_i,
  input  logic [W_P-1:0] data_i,
  output logic [W_P-1:0] cnt_o
);

  localparam logic [W_P-1:0] MAX_V = W_P'(MAX_P);

  // Load wins over counting; counting rolls over at either end.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)     cnt_o <= '0;
    else if (load_i) cnt_o <= data_i;
    else if (en_i) begin
      if (up_i) cnt_o <= (cnt_o == MAX_V) ? '0 : cnt_o + 1'b1;
      else      cnt_o <= (cnt_o == '0) ? MAX_V : cnt_o - 1'b1;
    end
  end

endmodule

// File: rtl/raster_tracker.sv
// Raster position tracker: one-deep valid/ready slice that tags each pixel
// with column/row, frame markers, border and 3x3-window-ready flags.
module raster_tracker
  import sobel_pkg::*;
#(
  parameter int DATA_W_P = 8,
  parameter int IMG_W_P  = IMG_W,
  parameter int IMG_H_P  = IMG_H,
  parameter int COL_W_P  = 10,
  parameter int ROW_W_P  = 9,
  parameter int FCNT_W_P = 16
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                clear_i,
  input  logic [DATA_W_P-1:0] data_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [DATA_W_P-1:0] data_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [COL_W_P-1:0]  col_o,
  output logic [ROW_W_P-1:0]  row_o,
  output logic                sof_o,
  output logic                eol_o,
  output logic                eof_o,
  output logic                border_o,
  output logic                win_valid_o,
  output logic                busy_o,
  output logic [FCNT_W_P-1:0] frame_cnt_o
);

  localparam logic [COL_W_P-1:0] COL_LAST = COL_W_P'(IMG_W_P - 1);
  localparam logic [ROW_W_P-1:0] ROW_LAST = ROW_W_P'(IMG_H_P - 1);

  logic [COL_W_P-1:0] col;
  logic [ROW_W_P-1:0] row;
  logic               accept, col_wrap, row_wrap;
  pixel_tag_t         tag_d, tag_q;
  rt_state_e          state_q, state_d;
  logic               unused_tag;

  // clear_i blocks the upstream handshake in its cycle.
  assign ready_o  = (!valid_o || ready_i) && !clear_i;
  assign accept   = valid_i && ready_o;
  assign col_wrap = (col == COL_LAST);
  assign row_wrap = (row == ROW_LAST);

  // Tags come from the counters before they advance.
  assign tag_d = make_tag(TAG_W'(col), TAG_W'(row), IMG_W_P, IMG_H_P);

  raster_tracker_counter #(.W_P(COL_W_P), .MAX_P(IMG_W_P - 1)) u_col_cnt (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .en_i   (accept),
    .up_i   (1'b1),
    .load_i ((accept && col_wrap) || clear_i),
    .data_i ('0),
    .cnt_o  (col)
  );

  raster_tracker_counter #(.W_P(ROW_W_P), .MAX_P(IMG_H_P - 1)) u_row_cnt (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .en_i   (accept && col_wrap),
    .up_i   (1'b1),
    .load_i ((accept && col_wrap && row_wrap) || clear_i),
    .data_i ('0),
    .cnt_o  (row)
  );

  // Completed-frame count; an aborted frame is never counted.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                                       frame_cnt_o <= '0;
    else if (!clear_i && accept && col_wrap && row_wrap) frame_cnt_o <= frame_cnt_o + 1'b1;
  end

  // Output slice: reload on accept (no bubble), drain when taken, else hold.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      tag_q   <= '0;
    end else if (clear_i) begin
      valid_o <= 1'b0;
    end else if (accept) begin
      valid_o <= 1'b1;
      data_o  <= data_i;
      tag_q   <= tag_d;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

  // Frame-activity state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Enter on the first pixel, leave on the last; sof and eof never coincide.
  always_comb begin
    state_d = state_q;
    if (clear_i) state_d = S_IDLE;
    else if (accept) begin
      if (tag_d.sof) state_d = S_ACTIVE;
      if (tag_d.eof) state_d = S_IDLE;
    end
  end

  assign busy_o      = (state_q == S_ACTIVE);
  assign col_o       = tag_q.col[COL_W_P-1:0];
  assign row_o       = tag_q.row[ROW_W_P-1:0];
  assign sof_o       = tag_q.sof;
  assign eol_o       = tag_q.eol;
  assign eof_o       = tag_q.eof;
  assign border_o    = tag_q.border;
  assign win_valid_o = tag_q.win_valid;
  // Upper tag bits beyond the configured counter widths are always zero.
  assign unused_tag  = ^{tag_q.col, tag_q.row};

endmodule
